// File: rtl/wbus_transfer_sequencer_pkg.sv
// Shared definitions for the WBUS transfer sequencer: FSM encoding and
// bus register indices.
package wbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } wbus_state_e;

  localparam int NREG_DEFAULT = 4;

  localparam logic [1:0] REG_A   = 2'd0;
  localparam logic [1:0] REG_TMP = 2'd1;
  localparam logic [1:0] REG_B   = 2'd2;
  localparam logic [1:0] REG_C   = 2'd3;

endpackage

// File: rtl/wbus_onehot_dec.sv
// Index-to-one-hot decoder. The output is all zero when i_en is low
// or when i_idx is outside 0..NREG-1.
module wbus_onehot_dec #(
  parameter int NREG  = 4,
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0] i_idx,
  input  logic             i_en,
  output logic [NREG-1:0]  o_onehot
);

  // Compare the index against each register position.
  always_comb begin
    o_onehot = {NREG{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      if (i_en && (i_idx == SEL_W'(i))) begin
        o_onehot[i] = 1'b1;
      end else begin
        o_onehot[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/wbus_transfer_sequencer.sv
// Sequences one WBUS register-to-register move per handshake through the
// states IDLE, DRIVE, LOAD and DONE. All outputs are registered.
module wbus_transfer_sequencer
  import wbus_pkg::*;
#(
  parameter int NREG  = NREG_DEFAULT,
  parameter int SEL_W = 2,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SEL_W-1:0] req_src,
  input  logic [SEL_W-1:0] req_dst,
  output logic [NREG-1:0]  E,
  output logic [NREG-1:0]  nL,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam logic [SEL_W:0] NREG_W = (SEL_W + 1)'(NREG);

  wbus_state_e      r_state;
  logic [SEL_W-1:0] r_src;
  logic [SEL_W-1:0] r_dst;
  logic             r_err;

  wbus_state_e      w_state_nxt;
  logic [SEL_W-1:0] w_src_nxt;
  logic [SEL_W-1:0] w_dst_nxt;
  logic             w_err_nxt;
  logic             w_req_ok;
  logic             w_e_en;
  logic             w_l_en;
  logic [NREG-1:0]  w_e_dec;
  logic [NREG-1:0]  w_l_dec;

  assign w_req_ok = (req_src != req_dst) &&
                    ({1'b0, req_src} < NREG_W) &&
                    ({1'b0, req_dst} < NREG_W);

  // Next-state logic; the request fields are captured only on acceptance in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_src_nxt   = r_src;
    w_dst_nxt   = r_dst;
    w_err_nxt   = r_err;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_src_nxt   = req_src;
          w_dst_nxt   = req_dst;
          w_err_nxt   = !w_req_ok;
          w_state_nxt = w_req_ok ? ST_DRIVE : ST_DONE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DRIVE: w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Enables are decoded from the next state, so the registered E/nL match the state they belong to.
  assign w_e_en = (w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_LOAD);
  assign w_l_en = (w_state_nxt == ST_LOAD);

  wbus_onehot_dec #(.NREG(NREG), .SEL_W(SEL_W)) u_e_dec (
    .i_idx    (w_src_nxt),
    .i_en     (w_e_en),
    .o_onehot (w_e_dec)
  );

  wbus_onehot_dec #(.NREG(NREG), .SEL_W(SEL_W)) u_l_dec (
    .i_idx    (w_dst_nxt),
    .i_en     (w_l_en),
    .o_onehot (w_l_dec)
  );

  // State, captured request, registered outputs and transfer counter.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state   <= ST_IDLE;
      r_src     <= {SEL_W{1'b0}};
      r_dst     <= {SEL_W{1'b0}};
      r_err     <= 1'b0;
      E         <= {NREG{1'b0}};
      nL        <= {NREG{1'b1}};
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      xfer_cnt  <= {CNT_W{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_src     <= w_src_nxt;
      r_dst     <= w_dst_nxt;
      r_err     <= w_err_nxt;
      E         <= w_e_dec;
      nL        <= ~w_l_dec;
      req_ready <= (w_state_nxt == ST_IDLE);
      busy      <= (w_state_nxt != ST_IDLE);
      done      <= (w_state_nxt == ST_DONE);
      err       <= (w_state_nxt == ST_DONE) && w_err_nxt;
      if (r_state == ST_LOAD) begin
        xfer_cnt <= xfer_cnt + CNT_W'(1);
      end else begin
        xfer_cnt <= xfer_cnt;
      end
    end
  end

endmodule

// File: tb/tb_wbus_transfer_sequencer.sv
// Directed bench for wbus_transfer_sequencer with a behavioural model of the
// four bus registers; a second instance with CNT_W=2 exercises counter wrap.
module tb_wbus_transfer_sequencer;
  import wbus_pkg::*;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       req_valid;
  logic [1:0] req_src;
  logic [1:0] req_dst;

  logic       req_ready, busy, done, err;
  logic [3:0] E, nL;
  logic [7:0] xfer_cnt;

  logic       w2_ready, w2_busy, w2_done, w2_err;
  logic [3:0] w2_E, w2_nL;
  logic [1:0] w2_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] regs [4];
  logic [7:0] bus;
  logic       init_done = 1'b0;

  always #5 CLK = ~CLK;

  wbus_transfer_sequencer #(.NREG(4), .SEL_W(2), .CNT_W(8)) dut (
    .CLK(CLK), .CLR(CLR), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .E(E), .nL(nL), .busy(busy),
    .done(done), .err(err), .xfer_cnt(xfer_cnt)
  );

  wbus_transfer_sequencer #(.NREG(4), .SEL_W(2), .CNT_W(2)) dut_w (
    .CLK(CLK), .CLR(CLR), .req_valid(req_valid), .req_ready(w2_ready),
    .req_src(req_src), .req_dst(req_dst), .E(w2_E), .nL(w2_nL), .busy(w2_busy),
    .done(w2_done), .err(w2_err), .xfer_cnt(w2_cnt)
  );

  // Bus register model: the enabled register drives the bus, low loads capture it.
  always_comb begin
    bus = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (E[i]) bus = regs[i];
    end
  end

  always @(posedge CLK) begin
    if (!init_done) begin
      regs[0] <= 8'h0A;
      regs[1] <= 8'h00;
      regs[2] <= 8'hBB;
      regs[3] <= 8'hCC;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!nL[i]) regs[i] <= bus;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Bus safety rules checked every cycle.
  always @(negedge CLK) begin
    if (init_done) begin
      chk("onehot0_E", 32'($onehot0(E)), 32'd1);
      chk("onehot0_nL", 32'($onehot0(~nL)), 32'd1);
      chk("E_nL_overlap", 32'(E & ~nL), 32'd0);
    end
  end

  initial begin
    CLR = 1'b1; req_valid = 1'b0; req_src = 2'd0; req_dst = 2'd0;
    tick();
    init_done = 1'b1;
    tick();
    CLR = 1'b0;
    tick();
    chk("rst_E", 32'(E), 32'h0);
    chk("rst_nL", 32'(nL), 32'hF);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'({done, err}), 32'd0);
    chk("rst_cnt", 32'(xfer_cnt), 32'd0);

    // A -> TMP
    req_valid = 1'b1; req_src = REG_A; req_dst = REG_TMP;
    tick();
    chk("a2t_drive_E", 32'(E), 32'h1);
    chk("a2t_drive_nL", 32'(nL), 32'hF);
    chk("a2t_drive_ready", 32'(req_ready), 32'd0);
    chk("a2t_drive_busy", 32'(busy), 32'd1);
    req_valid = 1'b0; req_src = REG_C; req_dst = REG_A;
    tick();
    chk("a2t_load_E", 32'(E), 32'h1);
    chk("a2t_load_nL", 32'(nL), 32'hD);
    chk("a2t_load_done", 32'(done), 32'd0);
    tick();
    chk("a2t_done_E", 32'(E), 32'h0);
    chk("a2t_done_nL", 32'(nL), 32'hF);
    chk("a2t_done", 32'({done, err}), 32'h2);
    chk("a2t_cnt", 32'(xfer_cnt), 32'd1);
    chk("a2t_tmp", 32'(regs[1]), 32'h0A);
    tick();
    chk("a2t_idle_done", 32'(done), 32'd0);
    chk("a2t_idle_ready", 32'(req_ready), 32'd1);

    // C -> B then B -> A with req_valid held high
    req_valid = 1'b1; req_src = REG_C; req_dst = REG_B;
    tick();
    chk("c2b_drive_E", 32'(E), 32'h8);
    req_src = REG_B; req_dst = REG_A;
    tick();
    chk("c2b_load_E", 32'(E), 32'h8);
    chk("c2b_load_nL", 32'(nL), 32'hB);
    tick();
    chk("c2b_done_E", 32'(E), 32'h0);
    chk("c2b_done_ready", 32'(req_ready), 32'd0);
    chk("c2b_b", 32'(regs[2]), 32'hCC);
    tick();
    chk("gap_E", 32'(E), 32'h0);
    chk("gap_ready", 32'(req_ready), 32'd1);
    tick();
    chk("b2a_drive_E", 32'(E), 32'h4);
    req_valid = 1'b0;
    tick();
    chk("b2a_load_nL", 32'(nL), 32'hE);
    tick();
    chk("b2a_done", 32'({done, err}), 32'h2);
    chk("b2a_cnt", 32'(xfer_cnt), 32'd3);
    chk("b2a_a", 32'(regs[0]), 32'hCC);
    tick();

    // Invalid request src == dst
    req_valid = 1'b1; req_src = REG_B; req_dst = REG_B;
    tick();
    chk("inv_E", 32'(E), 32'h0);
    chk("inv_nL", 32'(nL), 32'hF);
    chk("inv_done", 32'({done, err}), 32'h3);
    chk("inv_cnt", 32'(xfer_cnt), 32'd3);
    req_valid = 1'b0;
    tick();
    chk("inv_idle", 32'({done, err, req_ready}), 32'h1);

    // CLR during LOAD of TMP -> C
    req_valid = 1'b1; req_src = REG_TMP; req_dst = REG_C;
    tick();
    chk("clr_drive_E", 32'(E), 32'h2);
    req_valid = 1'b0;
    tick();
    chk("clr_load_nL", 32'(nL), 32'h7);
    CLR = 1'b1;
    #1;
    chk("clr_E", 32'(E), 32'h0);
    chk("clr_nL", 32'(nL), 32'hF);
    chk("clr_ready", 32'(req_ready), 32'd1);
    chk("clr_cnt", 32'(xfer_cnt), 32'd0);
    tick();
    chk("clr_nodone", 32'(done), 32'd0);
    chk("clr_c", 32'(regs[3]), 32'hCC);
    CLR = 1'b0;

    // Five A -> B transfers; narrow counter wraps
    for (int k = 1; k <= 5; k++) begin
      req_valid = 1'b1; req_src = REG_A; req_dst = REG_B;
      tick();
      chk("wrap_drive_E", 32'(E), 32'h1);
      req_valid = 1'b0;
      tick();
      tick();
      chk("wrap_done", 32'({done, err}), 32'h2);
      chk("wrap_cnt8", 32'(xfer_cnt), 32'(k));
      chk("wrap_cnt2", 32'(w2_cnt), 32'(k % 4));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
